boot_rom_arbiter: RTL and testbench

//   Shares the single-port boot ROM (registered address, 1-cycle read latency) between the

---
 rtl/boot_rom_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_boot_rom_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_arbiter.sv
// ----------------------------------------------------------------------------
// boot_rom_arbiter
//
// Purpose
//   Shares one single-port boot ROM between the core instruction-fetch port
//   and the core data port. Both ports speak the req/gnt/rvalid OBI-lite
//   protocol. The block arbitrates, drives the ROM chip select and word
//   address, and routes the ROM read data back to the port that was granted.
//   Writes, misaligned accesses and out-of-range accesses are granted, but
//   they never touch the ROM and are answered with an error response.
//
//   The ROM has a registered address and one cycle of read latency. Grants
//   are combinational from req, so a response comes back exactly one cycle
//   after its grant. A new grant may be issued in the same cycle as the
//   previous response, which sustains one access per cycle.
//
// Configuration macro
//   BOOT_ROM_ARB_RR_EN  undefined: fixed priority, the instruction port
//                                  wins every tie.
//                       defined:   round-robin on ties. A 1-bit pointer
//                                  records the last contested winner, and
//                                  the other port wins the next tie.
//
// Ports
//   CLK, RSTN                  clock, asynchronous active-low reset
//   instr_req_i / instr_addr_i fetch request and byte address
//   instr_gnt_o                fetch granted this cycle
//   instr_rvalid_o/_rdata_o/_err_o  fetch response
//   data_req_i / data_we_i / data_addr_i  data request, write enable, address
//   data_gnt_o                 data access granted this cycle
//   data_rvalid_o/_rdata_o/_err_o   data response
//   rom_csn_o                  ROM chip select, active low
//   rom_addr_o                 ROM word address
//   rom_rdata_i                ROM read data, valid 1 cycle after csn low
// ----------------------------------------------------------------------------
module boot_rom_arbiter #(
    parameter int unsigned ROM_ADDR_WIDTH = 10,
    parameter int unsigned ROM_WORDS      = 548,
    parameter int unsigned BUS_ADDR_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RSTN,

    input  logic                      instr_req_i,
    input  logic [BUS_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,

    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [BUS_ADDR_WIDTH-1:0] data_addr_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,

    output logic                      rom_csn_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i
);

    // Port indices. Index 0 is the instruction port and index 1 is the data
    // port. A set bit in a port-select value therefore means "data".
    localparam int unsigned NPORTS = 2;

    // The address must have bits above the word index. This means
    // BUS_ADDR_WIDTH must be greater than ROM_ADDR_WIDTH + 2.
    localparam int unsigned UPPER_LSB = ROM_ADDR_WIDTH + 2;

    // ------------------------------------------------------------------
    // Per-port request view
    // ------------------------------------------------------------------
    logic [NPORTS-1:0]         w_req;
    logic [NPORTS-1:0]         w_we;
    logic [NPORTS-1:0]         w_legal;
    logic [NPORTS-1:0]         w_gnt;
    logic [BUS_ADDR_WIDTH-1:0] w_addr [NPORTS];
    logic [ROM_ADDR_WIDTH-1:0] w_word [NPORTS];

    assign w_req     = {data_req_i, instr_req_i};
    // Instruction fetches can never write.
    assign w_we      = {data_we_i, 1'b0};
    assign w_addr[0] = instr_addr_i;
    assign w_addr[1] = data_addr_i;

    // Legality check for each port. An access is legal only if it is a read,
    // it is word aligned, no address bit above the word index is set, and
    // the word index is inside the populated part of the ROM.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port_check
            logic w_aligned;
            logic w_upper_zero;
            logic w_in_range;

            assign w_word[gi]    = w_addr[gi][ROM_ADDR_WIDTH+1:2];
            assign w_aligned     = (w_addr[gi][1:0] == 2'b00);
            assign w_upper_zero  = (w_addr[gi][BUS_ADDR_WIDTH-1:UPPER_LSB] == '0);
            assign w_in_range    = (32'(w_word[gi]) < ROM_WORDS);
            assign w_legal[gi]   = !w_we[gi] && w_aligned && w_upper_zero && w_in_range;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_tie;
    assign w_tie = w_req[0] & w_req[1];

`ifdef BOOT_ROM_ARB_RR_EN
    // Records the last contested winner: 1 = data won the last tie.
    // Its reset value is 1, so the instruction port wins the first tie.
    logic r_last_win_data;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_last_win_data <= 1'b1;
        end else if (w_tie) begin
            // Only tie cycles move the pointer.
            r_last_win_data <= w_gnt[1];
        end
    end
`endif

    always_comb begin
        w_gnt = '0;
        // While reset is asserted, all requests are ignored, so no grant
        // can leak out as a combinational path.
        if (RSTN) begin
            if (w_tie) begin
`ifdef BOOT_ROM_ARB_RR_EN
                w_gnt = r_last_win_data ? 2'b01 : 2'b10;
`else
                w_gnt = 2'b01;
`endif
            end else begin
                // A lone requester is granted immediately.
                w_gnt = w_req;
            end
        end
    end

    assign instr_gnt_o = w_gnt[0];
    assign data_gnt_o  = w_gnt[1];

    // ------------------------------------------------------------------
    // ROM access: only a legal, granted access drives the ROM
    // ------------------------------------------------------------------
    logic                      w_any_gnt;
    logic                      w_sel_port;
    logic                      w_sel_legal;
    logic [ROM_ADDR_WIDTH-1:0] w_sel_word;
    logic                      w_rom_access;
    logic [ROM_ADDR_WIDTH-1:0] r_rom_addr;

    assign w_any_gnt    = |w_gnt;
    assign w_sel_port   = w_gnt[1];
    assign w_sel_legal  = w_sel_port ? w_legal[1] : w_legal[0];
    assign w_sel_word   = w_sel_port ? w_word[1]  : w_word[0];
    assign w_rom_access = w_any_gnt & w_sel_legal;

    // The address bus shows the new word index in the grant cycle. In every
    // other cycle it holds the last legal address, so an idle cycle never
    // makes the ROM address pins toggle.
    assign rom_csn_o  = ~w_rom_access;
    assign rom_addr_o = w_rom_access ? w_sel_word : r_rom_addr;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rom_addr <= '0;
        end else if (w_rom_access) begin
            r_rom_addr <= w_sel_word;
        end
    end

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    // This register is loaded on every grant and describes the response
    // that is due in the next cycle. Each grant overwrites it, so the design
    // is fully pipelined. Responses come back in grant order because only
    // one access is ever in flight. Reset clears it, so any pending response
    // is dropped.
    logic r_rsp_valid;
    logic r_rsp_port;
    logic r_rsp_err;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_rsp_port <= w_sel_port;
                r_rsp_err  <= ~w_sel_legal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // Only the addressed port sees rvalid. ROM data is passed through only
    // for a legal access. An error response returns zero data.
    logic [NPORTS-1:0] w_rvalid;
    logic [NPORTS-1:0] w_err;
    logic [31:0]       w_rdata [NPORTS];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port_rsp
            assign w_rvalid[gi] = r_rsp_valid && (r_rsp_port == 1'(gi));
            assign w_err[gi]    = w_rvalid[gi] && r_rsp_err;
            assign w_rdata[gi]  = (w_rvalid[gi] && !r_rsp_err) ? rom_rdata_i : 32'h0;
        end
    endgenerate

    assign instr_rvalid_o = w_rvalid[0];
    assign instr_err_o    = w_err[0];
    assign instr_rdata_o  = w_rdata[0];
    assign data_rvalid_o  = w_rvalid[1];
    assign data_err_o     = w_err[1];
    assign data_rdata_o   = w_rdata[1];

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_boot_rom_arbiter
//
// Directed testbench for boot_rom_arbiter. Inputs are driven on the falling
// edge. Outputs are compared 1 ns later against a behavioural model of
// arbitration, legality and response order. A few hand-computed literal
// expectations pin down the model itself. The bench also acts as the ROM,
// with a registered read of one cycle of latency.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_boot_rom_arbiter;

    localparam int unsigned AW = 10;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        rom_csn_o;
    logic [AW-1:0] rom_addr_o;
    logic [31:0] rom_rdata_i = '0;

    boot_rom_arbiter #(.ROM_ADDR_WIDTH(AW), .ROM_WORDS(548), .BUS_ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o),
        .rom_csn_o(rom_csn_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
    );

    always #5 CLK = ~CLK;

    // ROM contents. Most words are {index, ~index}. Words 0 and 547 hold
    // their real boot-image values.
    logic [31:0] rom_mem [1024];
    always @(posedge CLK) begin
        if (!rom_csn_o) rom_rdata_i <= rom_mem[rom_addr_o];
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit port; bit err; logic [31:0] data; } rsp_t;
    rsp_t       m_q[$];
    bit         m_prefer_data = 1'b0;   // RR only: data wins the next tie
    logic [31:0] m_last_addr  = '0;

    function automatic bit legal(input logic [31:0] addr, input bit we);
        return !we && (addr % 4 == 0) && (addr < 548 * 4);
    endfunction

    task automatic compare_model();
        bit   ig = 0, dg = 0, has_rsp = 0;
        rsp_t r = '{port: 0, err: 0, data: '0};
        bit   lg = 0;
        logic [31:0] ga = '0;
        bit   gwe = 0;
        if (!RSTN) begin
            m_q.delete();
            m_prefer_data = 1'b0;
            m_last_addr   = '0;
        end else begin
            if (m_q.size() > 0) begin
                r = m_q.pop_front();
                has_rsp = 1;
            end
            if (instr_req_i && data_req_i) begin
`ifdef BOOT_ROM_ARB_RR_EN
                dg = m_prefer_data;
                ig = !m_prefer_data;
                m_prefer_data = ig;
`else
                ig = 1;
`endif
            end else begin
                ig = instr_req_i;
                dg = data_req_i;
            end
            if (ig) begin ga = instr_addr_i; gwe = 0; end
            if (dg) begin ga = data_addr_i;  gwe = data_we_i; end
            lg = (ig || dg) && legal(ga, gwe);
            if (lg) m_last_addr = ga / 4;
        end
        chk("instr_gnt", instr_gnt_o, ig);
        chk("data_gnt",  data_gnt_o,  dg);
        chk("rom_csn",   rom_csn_o,   !lg);
        chk("rom_addr",  rom_addr_o,  m_last_addr);
        chk("instr_rvalid", instr_rvalid_o, has_rsp && !r.port);
        chk("instr_err",    instr_err_o,    has_rsp && !r.port && r.err);
        chk("instr_rdata",  instr_rdata_o,  (has_rsp && !r.port) ? r.data : 32'h0);
        chk("data_rvalid",  data_rvalid_o,  has_rsp && r.port);
        chk("data_err",     data_err_o,     has_rsp && r.port && r.err);
        chk("data_rdata",   data_rdata_o,   (has_rsp && r.port) ? r.data : 32'h0);
        if (ig || dg) begin
            m_q.push_back('{port: dg, err: !lg, data: lg ? rom_mem[ga / 4] : 32'h0});
            $display("t=%0t grant %s addr=%h we=%0d legal=%0d", $time,
                     dg ? "data " : "instr", ga, gwe, lg);
        end
    endtask

    // One bus cycle. Drive on the falling edge, settle, then compare.
    task automatic cyc(input bit rst_n, input bit ireq, input logic [31:0] iaddr,
                       input bit dreq, input bit dwe, input logic [31:0] daddr);
        @(negedge CLK);
        RSTN = rst_n;
        instr_req_i = ireq; instr_addr_i = iaddr;
        data_req_i = dreq; data_we_i = dwe; data_addr_i = daddr;
        #1;
        compare_model();
    endtask

    task automatic idle();
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = {i[15:0], ~i[15:0]};
        rom_mem[0]   = 32'h0040006F;
        rom_mem[547] = 32'h100E4C00;

        // Reset: requests are present but must be ignored.
        cyc(0, 1, 32'h4, 1, 0, 32'h8);
        chk("rst_csn", rom_csn_o, 1'b1);
        chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
        cyc(0, 1, 32'h4, 1, 0, 32'h8);

        // Test 1: a single fetch from address 0.
        cyc(1, 1, 32'h0, 0, 0, 32'h0);
        chk("t1_gnt", instr_gnt_o, 1'b1);
        chk("t1_csn", rom_csn_o, 1'b0);
        idle();
        chk("t1_rvalid", instr_rvalid_o, 1'b1);
        chk("t1_rdata", instr_rdata_o, 32'h0040006F);
        chk("t1_err", instr_err_o, 1'b0);

        // Test 2: both ports hold req for 4 cycles.
        begin
            logic [3:0] ig_seq;
`ifdef BOOT_ROM_ARB_RR_EN
            ig_seq = 4'b0101;   // instr wins cycles 0 and 2
`else
            ig_seq = 4'b1111;
`endif
            for (int k = 0; k < 4; k++) begin
                cyc(1, 1, 32'h20, 1, 0, 32'h30);
                chk("t2_instr_gnt", instr_gnt_o, ig_seq[k]);
                chk("t2_data_gnt", data_gnt_o, !ig_seq[k]);
            end
            cyc(1, 0, 32'h0, 1, 0, 32'h30);   // data is granted alone
            chk("t2_data_lone", data_gnt_o, 1'b1);
            idle();
            chk("t2_data_rdata", data_rdata_o, 32'h000CFFF3);
        end

        // Test 3: a data write is rejected.
        cyc(1, 0, 32'h0, 1, 1, 32'h10);
        chk("t3_gnt", data_gnt_o, 1'b1);
        chk("t3_csn", rom_csn_o, 1'b1);
        idle();
        chk("t3_rvalid", data_rvalid_o, 1'b1);
        chk("t3_err", data_err_o, 1'b1);
        chk("t3_rdata", data_rdata_o, 32'h0);

        // Test 4: range, alignment and upper-bit boundaries.
        cyc(1, 0, 32'h0, 1, 0, 32'h890);     // word 548: out of range
        cyc(1, 0, 32'h0, 1, 0, 32'h6);       // misaligned
        chk("t4_890_err", data_err_o, 1'b1);
        cyc(1, 1, 32'h88C, 0, 0, 32'h0);     // word 547: last legal word
        chk("t4_6_err", data_err_o, 1'b1);
        cyc(1, 0, 32'h0, 1, 0, 32'h1000);    // an upper address bit is set
        chk("t4_88c_rdata", instr_rdata_o, 32'h100E4C00);
        chk("t4_88c_err", instr_err_o, 1'b0);
        cyc(1, 1, 32'h2, 0, 0, 32'h0);       // misaligned fetch
        chk("t4_1000_err", data_err_o, 1'b1);
        idle();
        chk("t4_i2_err", instr_err_o, 1'b1);

        // Test 5: back-to-back fetches, one access per cycle.
        cyc(1, 1, 32'h0, 0, 0, 32'h0);
        cyc(1, 1, 32'h4, 0, 0, 32'h0);
        chk("t5_rd0", instr_rdata_o, 32'h0040006F);
        cyc(1, 1, 32'h8, 1, 0, 32'h8);      // data loses or wins per config
        chk("t5_rd1", instr_rdata_o, 32'h0001FFFE);
        cyc(1, 0, 32'h0, 1, 0, 32'h8);
        idle();
        idle();

        // Test 6: reset during an access drops the pending response.
        cyc(1, 1, 32'h10, 0, 0, 32'h0);
        chk("t6_gnt", instr_gnt_o, 1'b1);
        cyc(0, 1, 32'h10, 1, 0, 32'h14);
        chk("t6_no_rvalid", instr_rvalid_o, 1'b0);
        chk("t6_rom_addr", rom_addr_o, 10'd0);
        cyc(0, 1, 32'h10, 1, 0, 32'h14);
        idle();
        chk("t6_after_rvalid", instr_rvalid_o, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
